// File: rtl/mmio_port_controller.sv
// Memory-mapped I/O port block: OUT, IN (synchronized), STATUS (W1C), TIMER.
// Ports: clk, reset (sync, active-high), Address/WriteData/MemWrite/MemRead
//   from the processor; PortIn pins; ReadData, IOSelect, PortOut, Irq out.
module mmio_port_controller #(
  parameter logic [31:0] IO_BASE  = 32'h1001_0040,
  parameter int          IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                IOSelect,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  logic [31:0]         out_q, out_d;
  logic [31:0]         tmr_q, tmr_d;
  logic                chg_q, chg_d;
  logic                tdone_q, tdone_d;
  logic [IN_WIDTH-1:0] s1_q, s1_d;
  logic [IN_WIDTH-1:0] s2_q, s2_d;
  logic [IN_WIDTH-1:0] prev_q, prev_d;

  logic [1:0]  offs;
  logic        sel_out, sel_in;
  logic        sel_stat, sel_tmr;
  logic        wr_en;
  logic        wr_out, wr_stat, wr_tmr;
  logic        chg_set, tdone_set;
  logic [31:0] rd_mux;
  logic        unused_addr;

  // Byte lane bits carry no meaning in a word-wide register window.
  assign unused_addr = ^Address[1:0];

  assign IOSelect = (Address[31:4] == IO_BASE[31:4]);
  assign offs     = Address[3:2];

  assign sel_out  = (offs == 2'd0);
  assign sel_in   = (offs == 2'd1);
  assign sel_stat = (offs == 2'd2);
  assign sel_tmr  = (offs == 2'd3);

  assign wr_en   = IOSelect & MemWrite;
  assign wr_out  = wr_en & sel_out;
  assign wr_stat = wr_en & sel_stat;
  assign wr_tmr  = wr_en & sel_tmr;

  // CHG fires once s2 and prev disagree, i.e. the 3rd edge after a pin change.
  assign chg_set   = (s2_q != prev_q);
  // Only a natural 1->0 decrement counts; a written load never does.
  assign tdone_set = ~wr_tmr & (tmr_q == 32'd1);

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      sel_out:  rd_mux = out_q;
      sel_in:   rd_mux = 32'(s2_q);
      sel_stat: rd_mux = {30'h0, tdone_q, chg_q};
      sel_tmr:  rd_mux = tmr_q;
      default:  rd_mux = 32'h0;
    endcase
  end

  // Reads come from the flops, so a same-cycle store returns the old value.
  assign ReadData = (IOSelect & MemRead) ? rd_mux : 32'h0;
  assign PortOut  = out_q;
  assign Irq      = chg_q | tdone_q;

  always_comb begin
    s1_d   = PortIn;
    s2_d   = s1_q;
    prev_d = s2_q;

    out_d = out_q;
    if (wr_out) begin
      out_d = WriteData;
    end

    tmr_d = tmr_q;
    if (wr_tmr) begin
      tmr_d = WriteData;
    end else if (tmr_q != 32'd0) begin
      tmr_d = tmr_q - 32'd1;
    end

    // Set beats a coincident write-1-to-clear.
    chg_d = chg_q;
    if (wr_stat & WriteData[0]) begin
      chg_d = 1'b0;
    end
    if (chg_set) begin
      chg_d = 1'b1;
    end

    tdone_d = tdone_q;
    if (wr_stat & WriteData[1]) begin
      tdone_d = 1'b0;
    end
    if (tdone_set) begin
      tdone_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      tmr_q   <= '0;
      chg_q   <= 1'b0;
      tdone_q <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
    end else begin
      out_q   <= out_d;
      tmr_q   <= tmr_d;
      chg_q   <= chg_d;
      tdone_q <= tdone_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: tb/tb_mmio_port_controller.sv
// Directed bench for mmio_port_controller.
// Drives loads/stores after each edge and checks against hand values.
module tb_mmio_port_controller;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        IOSelect;
  logic [31:0] PortOut;
  logic        Irq;

  int checks;
  int failures;

  localparam logic [31:0] A_OUT  = 32'h1001_0040;
  localparam logic [31:0] A_IN   = 32'h1001_0044;
  localparam logic [31:0] A_STAT = 32'h1001_0048;
  localparam logic [31:0] A_TMR  = 32'h1001_004C;
  localparam logic [31:0] A_MISS = 32'h1001_0050;

  mmio_port_controller dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .IOSelect  (IOSelect),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input  logic [31:0] a,
                    output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
  endtask

  logic [31:0] v;
  int          td_seen;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'h0, Irq}, 32'h0);
    rd(A_IN, v);   chk("rst_in", v, 32'h0);
    rd(A_TMR, v);  chk("rst_tmr", v, 32'h0);
    rd(A_STAT, v); chk("rst_stat", v, 32'h0);

    // OUT register and decode
    wr(A_OUT, 32'hDEAD_BEEF);
    chk("out_port", PortOut, 32'hDEAD_BEEF);
    rd(A_OUT, v);  chk("out_rd", v, 32'hDEAD_BEEF);
    rd(32'h1001_0043, v);
    chk("out_rd_lowbits", v, 32'hDEAD_BEEF);
    Address = A_OUT; #1;
    chk("iosel_hit_idle", {31'h0, IOSelect}, 32'h1);
    Address = A_MISS; WriteData = 32'h5555_5555;
    MemWrite = 1'b1; #1;
    chk("iosel_miss", {31'h0, IOSelect}, 32'h0);
    tick();
    MemWrite = 1'b0;
    chk("miss_portout", PortOut, 32'hDEAD_BEEF);
    rd(A_MISS, v); chk("miss_rd", v, 32'h0);
    Address = A_OUT; #1;
    chk("rd_no_memread", ReadData, 32'h0);

    // read during write returns the old value
    Address = A_OUT; WriteData = 32'h1111_2222;
    MemWrite = 1'b1; MemRead = 1'b1; #1;
    chk("rdw_old", ReadData, 32'hDEAD_BEEF);
    tick();
    MemWrite = 1'b0; MemRead = 1'b0;
    chk("rdw_new", PortOut, 32'h1111_2222);

    // IN is read-only
    wr(A_IN, 32'hFF);
    rd(A_IN, v); chk("in_ro", v, 32'h0);

    // input synchronizer and CHG
    PortIn = 8'hA5;
    tick();
    rd(A_IN, v); chk("sync_e1", v, 32'h0);
    tick();
    rd(A_IN, v); chk("sync_e2", v, 32'hA5);
    chk("irq_e2", {31'h0, Irq}, 32'h0);
    tick();
    chk("irq_e3", {31'h0, Irq}, 32'h1);
    rd(A_STAT, v); chk("chg_e3", v, 32'h1);
    wr(A_STAT, 32'h1);
    rd(A_STAT, v); chk("chg_clr", v, 32'h0);
    chk("irq_clr", {31'h0, Irq}, 32'h0);

    // timer countdown
    wr(A_TMR, 32'd3);
    rd(A_TMR, v); chk("tmr_3", v, 32'd3);
    tick();
    rd(A_TMR, v); chk("tmr_2", v, 32'd2);
    tick();
    rd(A_TMR, v); chk("tmr_1", v, 32'd1);
    rd(A_STAT, v); chk("tdone_pre", v, 32'h0);
    tick();
    rd(A_TMR, v); chk("tmr_0", v, 32'd0);
    rd(A_STAT, v); chk("tdone_set", v, 32'h2);
    chk("irq_tdone", {31'h0, Irq}, 32'h1);
    tick();
    tick();
    rd(A_TMR, v); chk("tmr_hold0", v, 32'd0);
    wr(A_STAT, 32'h2);
    rd(A_STAT, v); chk("tdone_clr", v, 32'h0);

    // write overrides decrement at TIMER = 1
    wr(A_TMR, 32'd1);
    wr(A_TMR, 32'd5);
    rd(A_TMR, v); chk("tmr_ovr", v, 32'd5);
    rd(A_STAT, v); chk("tdone_ovr", v, 32'h0);
    wr(A_TMR, 32'd0);
    rd(A_TMR, v); chk("tmr_load0", v, 32'd0);
    tick();
    rd(A_STAT, v); chk("tdone_load0", v, 32'h0);

    // set beats W1C of CHG
    PortIn = 8'h5A;
    tick(); tick(); tick();
    rd(A_STAT, v); chk("chg_again", v, 32'h1);
    PortIn = 8'h00;
    tick(); tick();
    wr(A_STAT, 32'h1);
    rd(A_STAT, v); chk("chg_set_wins", v, 32'h1);
    wr(A_STAT, 32'h1);
    rd(A_STAT, v); chk("chg_clr2", v, 32'h0);

    // reset mid-operation
    wr(A_OUT, 32'h1234);
    wr(A_TMR, 32'd10);
    PortIn = 8'hFF;
    tick(); tick(); tick();
    rd(A_TMR, v); chk("pre_rst_tmr", v, 32'd7);
    chk("pre_rst_irq", {31'h0, Irq}, 32'h1);
    Address = A_OUT; WriteData = 32'hFFFF;
    MemWrite = 1'b1; reset = 1'b1;
    tick();
    MemWrite = 1'b0; reset = 1'b0;
    chk("mid_rst_out", PortOut, 32'h0);
    chk("mid_rst_irq", {31'h0, Irq}, 32'h0);
    rd(A_TMR, v);  chk("mid_rst_tmr", v, 32'h0);
    rd(A_STAT, v); chk("mid_rst_stat", v, 32'h0);
    rd(A_IN, v);   chk("mid_rst_in", v, 32'h0);
    td_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      rd(A_TMR, v);
      if (v != 32'h0) td_seen++;
      rd(A_STAT, v);
      if (v[1]) td_seen++;
    end
    chk("post_rst_quiet", 32'(td_seen), 32'h0);
    rd(A_IN, v); chk("refill_in", v, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_port_controller.md
MMIO_PORT_CONTROLLER -- requirements
Module: mmio_port_controller

Interface
REQ-001 The block SHALL provide the following parameters:
- IO_BASE, default 32'h1001_0040, 16-byte-aligned base of the register window.
- IN_WIDTH, default 8, width of PortIn.

REQ-002 The block SHALL provide the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  processor data address (ALU result).
- WriteData  input  32  processor store data (rt register value).
- MemWrite  input  1  store strobe from Control.
- MemRead  input  1  load strobe from Control.
- PortIn  input  IN_WIDTH  asynchronous external input pins.
- ReadData  output  32  load data for the MemtoReg mux.
- IOSelect  output  1  high when Address hits the window; top level uses it to select ReadData over DataMemory and to suppress the DataMemory write.
- PortOut  output  32  registered output port.
- Irq  output  1  OR of pending status flags.

Function
REQ-003 Hit and offset SHALL be decoded as follows:
- IOSelect = (Address[31:4] == IO_BASE[31:4]), purely combinational.
- Register offset = Address[3:2]; Address[1:0] is ignored.

REQ-004 The register map SHALL be:
- 0: OUT, read/write, drives PortOut.
- 1: IN, read-only, holds the synchronized PortIn zero-extended to 32 bits.
- 2: STATUS, where bit0 = CHG, bit1 = TDONE, bits[31:2] read 0, and writing 1 to a bit clears it.
- 3: TIMER, read/write 32-bit down-counter.

REQ-005 Reads SHALL be combinational with zero latency:
- ReadData = selected register when IOSelect && MemRead.
- ReadData = 32'h0 otherwise.

REQ-006 Writes SHALL take effect at the rising clk edge when IOSelect && MemWrite. A write to IN SHALL be ignored.

REQ-007 If MemRead and MemWrite are both high in the same cycle, ReadData SHALL return the pre-write value.

REQ-008 PortIn SHALL pass through a 2-flop synchronizer (s1 <- PortIn, s2 <- s1). IN SHALL equal s2, so a PortIn change appears on IN after the 2nd rising edge.

REQ-009 A third register prev <- s2 SHALL be kept. At the edge where s2 != prev, CHG SHALL be set; a change is therefore flagged at the 3rd edge after the PortIn change.

REQ-010 TIMER SHALL behave as follows:
- Each cycle in which TIMER != 0 and no TIMER write is occurring, TIMER decrements by 1.
- TIMER holds at 0 and never wraps.

REQ-011 TDONE SHALL be set at the edge where TIMER goes from 1 to 0 by decrement. Loading 0 by a write SHALL NOT set TDONE.

REQ-012 A TIMER write SHALL override a decrement in the same cycle; TIMER becomes WriteData exactly.

REQ-013 When a set condition and a write-1-to-clear of the same STATUS bit coincide, the set SHALL win and the bit stays 1.

REQ-014 Irq SHALL be registered-flag driven: Irq = CHG | TDONE, combinational from the STATUS flops, with no extra latency.

REQ-015 MemWrite without IOSelect SHALL leave all registers unchanged. IOSelect SHALL NOT depend on MemRead or MemWrite.

Reset
REQ-016 On reset high at a rising edge, the following SHALL be cleared to 0, taking priority over every write, decrement and flag set in that cycle:
- OUT, TIMER, CHG, TDONE
- s1, s2, prev

REQ-017 After reset: PortOut = 0, Irq = 0, and IN reads 0 until the synchronizer refills.

REQ-018 Reset asserted mid-countdown SHALL leave TIMER = 0 and TDONE = 0, with no spurious TDONE on the following cycle.

Verification
REQ-019 OUT register: store 32'hDEAD_BEEF to 0x1001_0040 -> PortOut = 32'hDEAD_BEEF after the edge; a load from 0x1001_0040 returns it in the same cycle. A store to 0x1001_0050 -> IOSelect = 0 and PortOut unchanged.

REQ-020 Input synchronizer: PortIn goes 8'h00 -> 8'hA5 -> a load of 0x1001_0044 returns 32'h0000_00A5 after the 2nd edge; CHG = 1 and Irq = 1 after the 3rd edge; a store of 32'h1 to 0x1001_0048 clears CHG and Irq = 0.

REQ-021 Timer countdown: store 3 to 0x1001_004C -> TIMER reads 3, 2, 1, 0 on successive cycles; TDONE = 1 at the edge reaching 0; TIMER stays 0 afterwards.

REQ-022 Simultaneous events:
- A TIMER write of 5 while TIMER = 1 -> TIMER = 5 and TDONE stays 0.
- A W1C of CHG in the same cycle PortIn changes reach s2 -> CHG stays 1.

REQ-023 Reset mid-operation: OUT = 32'h1234, TIMER = 10, CHG = 1; assert reset for one cycle -> all registers 0 and Irq = 0; TIMER stays 0 over the next 12 cycles.
